// File: rtl/vcr_ovc_credit_ctrl.sv
// vcr_ovc_credit_ctrl: output-port OVC state and credit tracker.
// Two banks of num_vcs OVCs, private and shared. Each OVC is a small lane
// with an IDLE/ALLOC/DRAIN FSM and an occupancy counter. The shared bank
// also draws from one common pool of downstream slots.
// All outputs are decoded from registers only.

module vcr_ovc_credit_lane #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic flit,
  input  logic flit_tail,
  input  logic flit_blk,
  input  logic cred,
  output logic idle,
  output logic room,
  output logic flit_acc,
  output logic cred_acc,
  output logic err
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ALLOC = 2'd1, DRAIN = 2'd2} state_e;

  state_e         state_q, state_d;
  // Flits outstanding downstream. The private credit count is LIMIT - used.
  logic [W-1:0]   used_q, used_d;
  logic           gnt_ok, can_send;

  // Accept or reject this cycle's events; offending events leave state alone.
  always_comb begin
    gnt_ok   = gnt && (state_q == IDLE);
    // A flit may ride along with the grant that opens the packet.
    can_send = (state_q == ALLOC) || gnt_ok;
    flit_acc = flit && !flit_blk && can_send && (used_q != LIM);
    cred_acc = cred && (used_q != '0);
    err      = (gnt && !gnt_ok) ||
               (flit && (!can_send || (used_q == LIM))) ||
               (cred && (used_q == '0));
    used_d   = used_q;
    if (flit_acc && !cred_acc)      used_d = used_q + W'(1);
    else if (cred_acc && !flit_acc) used_d = used_q - W'(1);
  end

  // Next-state: a credit landing this cycle already counts toward drain done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_ok) state_d = (flit_acc && flit_tail) ? DRAIN : ALLOC;
      ALLOC:   if (flit_acc && flit_tail) state_d = DRAIN;
      DRAIN:   if (used_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
    end
  end

  // Registered-only status toward the allocator.
  always_comb begin
    idle = (state_q == IDLE);
    room = (used_q != LIM);
  end
endmodule

module vcr_ovc_credit_ctrl #(
  parameter int num_vcs           = 15,
  parameter int credits_per_vc    = 8,
  parameter int shared_credits    = 16,
  parameter int max_shared_per_vc = 4,
  localparam int PW = $clog2(shared_credits + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [num_vcs-1:0] vc_gnt_ovc,
  input  logic [num_vcs-1:0] vc_gnt_shared_ovc,
  input  logic               flit_valid,
  input  logic [num_vcs-1:0] flit_sel_ovc,
  input  logic               flit_sel_shared,
  input  logic               flit_tail,
  input  logic               cred_valid,
  input  logic [num_vcs-1:0] cred_sel_ovc,
  input  logic               cred_shared,
  output logic [num_vcs-1:0] elig_ovc,
  output logic [num_vcs-1:0] elig_shared_ovc,
  output logic [num_vcs-1:0] free_ovc,
  output logic [num_vcs-1:0] free_shared_ovc,
  output logic [PW-1:0]      pool_count,
  output logic               error
);
  localparam logic [PW-1:0] POOL_MAX = PW'(shared_credits);

  logic               flit_ok, cred_ok, pool_err;
  logic [num_vcs-1:0] pf, sf, pc, sc;
  logic [num_vcs-1:0] p_err, s_err, s_room;
  logic [num_vcs-1:0] p_facc, p_cacc, s_facc, s_cacc;
  logic [PW-1:0]      pool_q, pool_d;
  logic               err_q, err_d;
  logic               acc_unused;

  // The private bank has no pool, so its acceptance strobes go nowhere.
  assign acc_unused = ^{p_facc, p_cacc};

  // Route qualified flit/credit strobes to the addressed bank; a malformed
  // select is dropped entirely.
  always_comb begin
    flit_ok  = flit_valid && $onehot(flit_sel_ovc);
    cred_ok  = cred_valid && $onehot(cred_sel_ovc);
    pool_err = flit_ok && flit_sel_shared && (pool_q == '0);
    pf = (flit_ok && !flit_sel_shared) ? flit_sel_ovc : '0;
    sf = (flit_ok &&  flit_sel_shared) ? flit_sel_ovc : '0;
    pc = (cred_ok && !cred_shared)     ? cred_sel_ovc : '0;
    sc = (cred_ok &&  cred_shared)     ? cred_sel_ovc : '0;
  end

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    vcr_ovc_credit_lane #(.LIMIT(credits_per_vc)) u_priv (
      .clk(clk), .reset(reset), .gnt(vc_gnt_ovc[v]), .flit(pf[v]),
      .flit_tail(flit_tail), .flit_blk(1'b0), .cred(pc[v]),
      .idle(elig_ovc[v]), .room(free_ovc[v]), .flit_acc(p_facc[v]),
      .cred_acc(p_cacc[v]), .err(p_err[v])
    );
    vcr_ovc_credit_lane #(.LIMIT(max_shared_per_vc)) u_shrd (
      .clk(clk), .reset(reset), .gnt(vc_gnt_shared_ovc[v]), .flit(sf[v]),
      .flit_tail(flit_tail), .flit_blk(pool_err), .cred(sc[v]),
      .idle(elig_shared_ovc[v]), .room(s_room[v]), .flit_acc(s_facc[v]),
      .cred_acc(s_cacc[v]), .err(s_err[v])
    );
  end

  // Pool nets accepted shared flits against accepted shared credits.
  always_comb begin
    pool_d = pool_q;
    if ((|s_facc) && !(|s_cacc))
      pool_d = pool_q - PW'(1);
    else if ((|s_cacc) && !(|s_facc) && (pool_q != POOL_MAX))
      pool_d = pool_q + PW'(1);
    err_d = err_q | pool_err | (|p_err) | (|s_err) |
            (flit_valid && !$onehot(flit_sel_ovc)) |
            (cred_valid && !$onehot(cred_sel_ovc));
  end

  // Pool and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pool_q <= POOL_MAX;
      err_q  <= 1'b0;
    end else begin
      pool_q <= pool_d;
      err_q  <= err_d;
    end
  end

  // Shared availability needs both pool space and per-OVC headroom.
  always_comb begin
    free_shared_ovc = s_room & {num_vcs{pool_q != '0}};
    pool_count      = pool_q;
    error           = err_q;
  end
endmodule
